// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter. A hold counter bounds the owner's tenure,
// and preemption is deferred while a transfer is in flight.
module bus_arbiter #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic m1_req,
   input  logic m2_req,
   input  logic bus_busy,
   output logic m1_grant,
   output logic m2_grant,
   output logic mux_sel,
   output logic bus_idle
);

   localparam int unsigned      CNT_W    = 8;
   localparam logic [CNT_W-1:0] HOLD_SAT = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_THR = CNT_W'(MAX_HOLD - 1);
   localparam logic             OWNER_M1 = 1'b0;
   localparam logic             OWNER_M2 = 1'b1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GRANT_M1 = 2'd1,
      GRANT_M2 = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_hold_cnt;
   logic [CNT_W-1:0]   w_hold_cnt_nxt;
   logic               r_last_owner;
   logic               w_last_owner_nxt;
   logic               r_m1_grant;
   logic               r_m2_grant;
   logic               r_mux_sel;
   logic               r_bus_idle;
   logic               w_preempt;
   logic               w_in_grant;

   assign w_in_grant = (r_state == GRANT_M1) || (r_state == GRANT_M2);

   // Owner has used its hold time, the other master waits and the bus is quiet
   assign w_preempt = (r_hold_cnt >= HOLD_THR) && !bus_busy &&
                      ((r_state == GRANT_M1) ? m2_req : m1_req);

   always_comb begin
      w_state_nxt      = r_state;
      w_hold_cnt_nxt   = r_hold_cnt;
      w_last_owner_nxt = r_last_owner;

      case (r_state)
         IDLE, RELEASE: begin
            if (m1_req && (!m2_req || (r_last_owner == OWNER_M2))) begin
               w_state_nxt = GRANT_M1;
            end else if (m2_req) begin
               w_state_nxt = GRANT_M2;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         GRANT_M1: if (!m1_req || w_preempt) w_state_nxt = RELEASE;
         GRANT_M2: if (!m2_req || w_preempt) w_state_nxt = RELEASE;
         default:  w_state_nxt = IDLE;
      endcase

      // New tenure restarts the counter and records the owner for round-robin
      if (((w_state_nxt == GRANT_M1) || (w_state_nxt == GRANT_M2)) &&
          (w_state_nxt != r_state)) begin
         w_hold_cnt_nxt   = '0;
         w_last_owner_nxt = (w_state_nxt == GRANT_M2) ? OWNER_M2 : OWNER_M1;
      end else if (w_in_grant && (r_hold_cnt < HOLD_SAT)) begin
         w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_hold_cnt   <= '0;
         r_last_owner <= OWNER_M2;
         r_m1_grant   <= 1'b0;
         r_m2_grant   <= 1'b0;
         r_mux_sel    <= OWNER_M1;
         r_bus_idle   <= 1'b1;
      end else begin
         r_state      <= w_state_nxt;
         r_hold_cnt   <= w_hold_cnt_nxt;
         r_last_owner <= w_last_owner_nxt;
         r_m1_grant   <= (r_state == GRANT_M1);
         r_m2_grant   <= (r_state == GRANT_M2);
         r_bus_idle   <= (r_state == IDLE) || (r_state == RELEASE);
         // Select moves only together with the grant it belongs to
         if (w_in_grant) r_mux_sel <= r_last_owner;
      end
   end

   assign m1_grant = r_m1_grant;
   assign m2_grant = r_m2_grant;
   assign mux_sel  = r_mux_sel;
   assign bus_idle = r_bus_idle;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter (MAX_HOLD=4): directed vectors scored through a queue,
// followed by a random request/busy soak checked against protocol invariants.
module tb_bus_arbiter;

   localparam logic [3:0] E_I0 = 4'b0001;  // {m1_grant, m2_grant, mux_sel, bus_idle}
   localparam logic [3:0] E_I1 = 4'b0011;
   localparam logic [3:0] E_G1 = 4'b1000;
   localparam logic [3:0] E_G2 = 4'b0110;

   typedef struct {
      int         cyc;
      logic [3:0] exp;
      int         id;
   } sb_t;

   logic clk;
   logic reset;
   logic m1_req;
   logic m2_req;
   logic bus_busy;
   logic m1_grant;
   logic m2_grant;
   logic mux_sel;
   logic bus_idle;

   int  cyc = 0;
   int  n_checks = 0;
   int  n_fail = 0;
   int  vec_id = 0;
   int  seen = 0;
   sb_t sb[$];

   logic       p_rst, p_m1, p_m2;   // inputs sampled at the latest edge
   logic       q_rst, q_m1, q_m2;   // inputs sampled one edge earlier
   logic [3:0] p_out;               // outputs after the previous edge
   logic [3:0] cur;
   sb_t        e;

   bus_arbiter #(.MAX_HOLD(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .m1_req   (m1_req),
      .m2_req   (m2_req),
      .bus_busy (bus_busy),
      .m1_grant (m1_grant),
      .m2_grant (m2_grant),
      .mux_sel  (mux_sel),
      .bus_idle (bus_idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic drive(input logic rst, input logic m1, input logic m2,
                        input logic busy, input logic pulse, input logic [3:0] exp);
      @(posedge clk);
      #1;
      reset    = rst;
      m1_req   = m1;
      m2_req   = m2;
      bus_busy = busy;
      sb.push_back('{cyc: cyc + 1, exp: exp, id: vec_id});
      vec_id++;
      if (pulse) begin
         #1 m2_req = 1'b1;
         #1 m2_req = 1'b0;
      end
   endtask

   // Monitor: scoreboard pops plus invariants every cycle
   initial begin
      forever begin
         @(negedge clk);
         cur = {m1_grant, m2_grant, mux_sel, bus_idle};
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.cyc != cyc || cur !== e.exp) begin
               n_fail++;
               $display("FAIL vec%0d: g1/g2/mux/idle=%b required %b (cycle %0d, due %0d)",
                        e.id, cur, e.exp, cyc, e.cyc);
            end
         end
         if (seen >= 2) begin
            n_checks++;
            if (m1_grant && m2_grant) begin
               n_fail++;
               $display("FAIL exclusive: both grants high at cycle %0d", cyc);
            end
            if (!p_rst) begin
               if (m1_grant || m2_grant) begin
                  n_checks++;
                  if (mux_sel !== m2_grant) begin
                     n_fail++;
                     $display("FAIL mux_owner: mux_sel=%b with grants %b%b at cycle %0d",
                              mux_sel, m1_grant, m2_grant, cyc);
                  end
               end
               if (mux_sel !== p_out[1]) begin
                  n_checks++;
                  if (!((m1_grant && !p_out[3]) || (m2_grant && !p_out[2]))) begin
                     n_fail++;
                     $display("FAIL mux_stable: mux_sel %b->%b without new grant at cycle %0d",
                              p_out[1], mux_sel, cyc);
                  end
               end
               if (m1_grant && !p_out[3]) begin
                  n_checks++;
                  if (!(q_m1 && !q_rst)) begin
                     n_fail++;
                     $display("FAIL rise_m1: grant without request two edges back at cycle %0d", cyc);
                  end
               end
               if (m2_grant && !p_out[2]) begin
                  n_checks++;
                  if (!(q_m2 && !q_rst)) begin
                     n_fail++;
                     $display("FAIL rise_m2: grant without request two edges back at cycle %0d", cyc);
                  end
               end
               if (p_out[0] && !q_rst) begin
                  n_checks++;
                  if ((!q_m1 && !q_m2 && !(bus_idle && !m1_grant && !m2_grant)) ||
                      ( q_m1 && !q_m2 && !m1_grant) ||
                      (!q_m1 &&  q_m2 && !m2_grant) ||
                      ( q_m1 &&  q_m2 && !(m1_grant || m2_grant))) begin
                     n_fail++;
                     $display("FAIL latency: reqs %b%b from idle gave g1/g2/mux/idle=%b at cycle %0d",
                              q_m1, q_m2, cur, cyc);
                  end
               end
            end
         end
         q_rst = p_rst;
         q_m1  = p_m1;
         q_m2  = p_m2;
         p_rst = reset;
         p_m1  = m1_req;
         p_m2  = m2_req;
         p_out = cur;
         seen++;
      end
   end

   initial begin
      reset    = 1'b1;
      m1_req   = 1'b0;
      m2_req   = 1'b0;
      bus_busy = 1'b0;

      // reset, requests ignored in reset, single request
      drive(1, 0, 0, 0, 0, E_I0);
      drive(1, 1, 0, 0, 0, E_I0);
      drive(0, 0, 0, 0, 0, E_I0);
      drive(0, 1, 0, 0, 0, E_I0);
      drive(0, 1, 0, 0, 0, E_G1);
      drive(0, 0, 0, 0, 0, E_G1);
      drive(0, 0, 0, 0, 0, E_I0);
      drive(0, 0, 0, 0, 0, E_I0);
      // tie after reset, hand-over through RELEASE, second tie
      drive(1, 0, 0, 0, 0, E_I0);
      drive(0, 1, 1, 0, 0, E_I0);
      drive(0, 1, 1, 0, 0, E_G1);
      drive(0, 0, 1, 0, 0, E_G1);
      drive(0, 0, 1, 0, 0, E_I0);
      drive(0, 0, 1, 0, 0, E_G2);
      drive(0, 0, 0, 0, 0, E_G2);
      drive(0, 0, 0, 0, 0, E_I1);
      drive(0, 1, 1, 0, 0, E_I1);
      // M1 held 4 cycles then preempted in favour of M2
      drive(0, 1, 1, 0, 0, E_G1);
      drive(0, 1, 1, 0, 0, E_G1);
      drive(0, 1, 1, 0, 0, E_G1);
      drive(0, 1, 1, 0, 0, E_G1);
      drive(0, 1, 1, 0, 0, E_I0);
      drive(0, 1, 1, 0, 0, E_G2);
      drive(0, 1, 0, 0, 0, E_G2);
      drive(0, 1, 0, 0, 0, E_I1);
      // preemption deferred by five busy cycles
      drive(0, 1, 1, 0, 0, E_G1);
      drive(0, 1, 1, 0, 0, E_G1);
      drive(0, 1, 1, 0, 0, E_G1);
      for (int i = 0; i < 5; i++) drive(0, 1, 1, 1, 0, E_G1);
      drive(0, 1, 1, 0, 0, E_G1);
      drive(0, 1, 1, 0, 0, E_I0);
      drive(0, 1, 1, 0, 0, E_G2);
      // challenger withdraws: owner keeps grant, counter stays saturated
      drive(0, 0, 1, 0, 0, E_G2);
      drive(0, 0, 1, 0, 0, E_G2);
      drive(0, 0, 1, 0, 0, E_G2);
      drive(0, 0, 1, 0, 0, E_G2);
      drive(0, 1, 1, 0, 0, E_G2);
      drive(0, 1, 1, 0, 0, E_I1);
      drive(0, 1, 1, 0, 0, E_G1);
      // reset while M2 owns a busy bus, then a tie
      drive(0, 0, 1, 0, 0, E_G1);
      drive(0, 0, 1, 0, 0, E_I0);
      drive(0, 0, 1, 0, 0, E_G2);
      drive(1, 0, 1, 1, 0, E_I0);
      drive(0, 1, 1, 0, 0, E_I0);
      drive(0, 1, 1, 0, 0, E_G1);
      drive(0, 0, 0, 0, 0, E_G1);
      // unsampled pulse, busy ignored when granting and on voluntary release
      drive(0, 0, 0, 0, 1, E_I0);
      drive(0, 0, 0, 0, 0, E_I0);
      drive(0, 0, 1, 1, 0, E_I0);
      drive(0, 0, 1, 1, 0, E_G2);
      drive(0, 0, 0, 1, 0, E_G2);
      drive(0, 0, 0, 1, 0, E_I1);
      drive(0, 0, 0, 0, 0, E_I1);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expected entries never compared, required 0", sb.size());
      end

      // random soak: sticky requests, frequent busy, rare resets
      for (int i = 0; i < 10000; i++) begin
         @(posedge clk);
         #1;
         reset    = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 3) == 0) m1_req = ~m1_req;
         if ($urandom_range(0, 3) == 0) m2_req = ~m2_req;
         bus_busy = ($urandom_range(0, 2) == 0);
      end
      @(posedge clk);
      #1;
      reset  = 1'b0;
      m1_req = 1'b0;
      m2_req = 1'b0;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
